// File: rtl/alu_issue_sched.sv
// Issue scheduler: round-robin arbitration between two requesters, RAW holdback
// against a writeback-latency scoreboard, and one registered issue word per cycle.
module alu_issue_sched #(
    parameter int  RW     = 10,
    parameter int  FW     = 4,
    parameter int  AW     = 10,
    parameter int  WB_LAT = 3,
    localparam int IW     = 3*RW + FW + AW
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [IW-1:0] req0_instr,
    input  logic          req1_valid,
    input  logic [IW-1:0] req1_instr,
    output logic          req0_ready,
    output logic          req1_ready,
    output logic          iss_valid,
    output logic [RW-1:0] iss_rs1,
    output logic [RW-1:0] iss_rs2,
    output logic [RW-1:0] iss_rd,
    output logic [FW-1:0] iss_func,
    output logic [AW-1:0] iss_addr,
    output logic          hazard_stall,
    output logic          err
);
    localparam int SB_N = WB_LAT - 1;
    localparam int SBW  = SB_N * RW;
    localparam int NF   = 2**FW;
    // Bit n set when function code n reads that source (codes 12 and up read nothing).
    localparam logic [NF-1:0] USE_RS1 = NF'(16'h0DEF);
    localparam logic [NF-1:0] USE_RS2 = NF'(16'h02F7);

    logic                    ptr;
    logic [SB_N-1:0]         sb_v;
    logic [SB_N-1:0][RW-1:0] sb_rd;

    logic          elig0_p0, elig1_p0;
    logic          gnt0_p0, gnt1_p0, any_gnt_p0, legal_p0;
    logic [IW-1:0] sel_p0;

    function automatic logic is_legal(input logic [FW-1:0] f);
        return f < FW'(12);
    endfunction

    function automatic logic raw_hazard(input logic [FW-1:0] f,
                                        input logic [RW-1:0] rs1,
                                        input logic [RW-1:0] rs2,
                                        input logic [SB_N-1:0] v,
                                        input logic [SB_N-1:0][RW-1:0] rd);
        logic h;
        h = 1'b0;
        for (int i = 0; i < SB_N; i++) begin
            if (v[i] && ((USE_RS1[f] && rs1 == rd[i]) || (USE_RS2[f] && rs2 == rd[i])))
                h = 1'b1;
        end
        return h;
    endfunction

    // Stage p0: eligibility and combinational grant
    always_comb begin
        elig0_p0 = rst_n && req0_valid &&
                   (!is_legal(req0_instr[IW-1 -: FW]) ||
                    !raw_hazard(req0_instr[IW-1 -: FW], req0_instr[AW+2*RW-1 -: RW],
                                req0_instr[AW+RW-1 -: RW], sb_v, sb_rd));
        elig1_p0 = rst_n && req1_valid &&
                   (!is_legal(req1_instr[IW-1 -: FW]) ||
                    !raw_hazard(req1_instr[IW-1 -: FW], req1_instr[AW+2*RW-1 -: RW],
                                req1_instr[AW+RW-1 -: RW], sb_v, sb_rd));
        gnt0_p0    = elig0_p0 && (!elig1_p0 || !ptr);
        gnt1_p0    = elig1_p0 && (!elig0_p0 || ptr);
        any_gnt_p0 = gnt0_p0 || gnt1_p0;
        sel_p0     = gnt1_p0 ? req1_instr : req0_instr;
        legal_p0   = is_legal(sel_p0[IW-1 -: FW]);
    end

    assign req0_ready = gnt0_p0;
    assign req1_ready = gnt1_p0;

    // Stage p1: registered issue word, flags, pointer and scoreboard valids
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= 1'b0;
            sb_v         <= '0;
            iss_valid    <= 1'b0;
            err          <= 1'b0;
            hazard_stall <= 1'b0;
            iss_rs1      <= '0;
            iss_rs2      <= '0;
            iss_rd       <= '0;
            iss_func     <= '0;
            iss_addr     <= '0;
        end else begin
            sb_v         <= SB_N'({sb_v, any_gnt_p0 && legal_p0});
            iss_valid    <= any_gnt_p0 && legal_p0;
            err          <= any_gnt_p0 && !legal_p0;
            hazard_stall <= (req0_valid || req1_valid) && !any_gnt_p0;
            if (any_gnt_p0)
                ptr <= gnt0_p0;
            if (any_gnt_p0 && legal_p0) begin
                iss_func <= sel_p0[IW-1 -: FW];
                iss_rd   <= sel_p0[AW+3*RW-1 -: RW];
                iss_rs1  <= sel_p0[AW+2*RW-1 -: RW];
                iss_rs2  <= sel_p0[AW+RW-1 -: RW];
                iss_addr <= sel_p0[AW-1:0];
            end
        end
    end

    // Destination tags only matter where the matching valid bit is set.
    always_ff @(posedge clk1) begin
        sb_rd <= SBW'({sb_rd, sel_p0[AW+3*RW-1 -: RW]});
    end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Self-checking bench for alu_issue_sched: directed scenarios plus a randomized
// run against a timestamp-based reference model.
module tb_alu_issue_sched;
    localparam int RW     = 10;
    localparam int FW     = 4;
    localparam int AW     = 10;
    localparam int WB_LAT = 3;
    localparam int IW     = 3*RW + FW + AW;

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [IW-1:0] req0_instr, req1_instr;
    logic          req0_ready, req1_ready;
    logic          iss_valid, hazard_stall, err;
    logic [RW-1:0] iss_rs1, iss_rs2, iss_rd;
    logic [FW-1:0] iss_func;
    logic [AW-1:0] iss_addr;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_sched #(.RW(RW), .FW(FW), .AW(AW), .WB_LAT(WB_LAT)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_instr(req0_instr),
        .req1_valid(req1_valid), .req1_instr(req1_instr),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_func(iss_func), .iss_addr(iss_addr),
        .hazard_stall(hazard_stall), .err(err)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [IW-1:0] mk(input int f, input int rd, input int rs1,
                                         input int rs2, input int addr);
        return {FW'(f), RW'(rd), RW'(rs1), RW'(rs2), AW'(addr)};
    endfunction

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_instr = '0;   req1_instr = '0;
        repeat (2) @(posedge clk1);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_instr = mk(0, 9, 10, 11, 12);
        req1_valid = 1'b0; req1_instr = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if ({req1_ready, req0_ready} !== 2'b00) begin
                n_fail++; $display("FAIL reset_ready c=%0d got %b exp 00", c, {req1_ready, req0_ready});
            end
            n_tests++;
            if ({iss_valid, hazard_stall, err, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr} !== '0) begin
                n_fail++; $display("FAIL reset_outputs c=%0d got v=%b s=%b e=%b rd=%0d exp all 0",
                                   c, iss_valid, hazard_stall, err, iss_rd);
            end
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_grant got %b exp 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        n_tests++;
        if ({iss_valid, iss_rd} !== {1'b1, RW'(9)}) begin
            n_fail++; $display("FAIL reset_first_issue got v=%b rd=%0d exp v=1 rd=9", iss_valid, iss_rd);
        end
    endtask

    task automatic test_single_issue();
        do_reset();
        req0_valid = 1'b1; req0_instr = mk(0, 1, 2, 3, 5);
        #1;
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++; $display("FAIL single_ready got %b exp 01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0;
        n_tests++;
        if ({iss_valid, iss_rd, iss_rs1, iss_rs2, iss_func, iss_addr} !==
            {1'b1, RW'(1), RW'(2), RW'(3), FW'(0), AW'(5)}) begin
            n_fail++; $display("FAIL single_issue got v=%b rd=%0d rs1=%0d rs2=%0d f=%0d a=%0d exp 1/1/2/3/0/5",
                               iss_valid, iss_rd, iss_rs1, iss_rs2, iss_func, iss_addr);
        end
        tick();
        n_tests++;
        if ({iss_valid, hazard_stall, iss_rd} !== {1'b0, 1'b0, RW'(1)}) begin
            n_fail++; $display("FAIL single_idle_hold got v=%b s=%b rd=%0d exp v=0 s=0 rd=1",
                               iss_valid, hazard_stall, iss_rd);
        end
    endtask

    task automatic test_raw_stall();
        do_reset();
        req0_valid = 1'b1; req0_instr = mk(0, 4, 1, 2, 0);
        #1;
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL raw_producer_ready got %b exp 1", req0_ready);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) req0_instr = mk(0, 5, 4, 3, 7);
            #1;
            n_tests++;
            if ({req0_ready, hazard_stall} !== {c == 3, c >= 2}) begin
                n_fail++; $display("FAIL raw_stall c=%0d got ready=%b stall=%b exp ready=%b stall=%b",
                                   c, req0_ready, hazard_stall, c == 3, c >= 2);
            end
        end
        tick();
        req0_valid = 1'b0;
        n_tests++;
        if ({iss_valid, iss_rs1, iss_rd, hazard_stall} !== {1'b1, RW'(4), RW'(5), 1'b0}) begin
            n_fail++; $display("FAIL raw_dependent_issue got v=%b rs1=%0d rd=%0d s=%b exp 1/4/5/0",
                               iss_valid, iss_rs1, iss_rd, hazard_stall);
        end
        // rs2-only reader whose rs1 field happens to match: no dependency
        do_reset();
        req0_valid = 1'b1; req0_instr = mk(0, 4, 1, 2, 0);
        tick();
        req0_instr = mk(4, 6, 4, 3, 0);
        #1;
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL raw_rs2only_ready got %b exp 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        n_tests++;
        if ({iss_valid, iss_func, hazard_stall} !== {1'b1, FW'(4), 1'b0}) begin
            n_fail++; $display("FAIL raw_rs2only_issue got v=%b f=%0d s=%b exp 1/4/0",
                               iss_valid, iss_func, hazard_stall);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_r;
        int         n0, n1, last_rd;
        do_reset();
        n0 = 0; n1 = 0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_instr = mk(0, 20, 100, 200, 0);
        req1_instr = mk(1, 40, 120, 220, 0);
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_r = (c % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++;
            if ({req1_ready, req0_ready} !== exp_r) begin
                n_fail++; $display("FAIL rr_grant c=%0d got %b exp %b", c, {req1_ready, req0_ready}, exp_r);
            end
            last_rd = (c % 2 == 0) ? 20 + n0 : 40 + n1;
            tick();
            n_tests++;
            if ({iss_valid, iss_rd} !== {1'b1, RW'(last_rd)}) begin
                n_fail++; $display("FAIL rr_issue c=%0d got v=%b rd=%0d exp v=1 rd=%0d", c, iss_valid, iss_rd, last_rd);
            end
            if (c % 2 == 0) begin n0++; req0_instr = mk(0, 20 + n0, 100 + n0, 200 + n0, 0); end
            else            begin n1++; req1_instr = mk(1, 40 + n1, 120 + n1, 220 + n1, 0); end
        end
        // req0 blocked on r4 for two cycles while req1 keeps flowing
        do_reset();
        req1_valid = 1'b1; req1_instr = mk(0, 4, 50, 51, 0);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin req0_valid = 1'b1; req0_instr = mk(0, 30, 4, 52, 0); end
            #1;
            exp_r = (c == 3) ? 2'b01 : 2'b10;
            n_tests++;
            if ({req1_ready, req0_ready} !== exp_r) begin
                n_fail++; $display("FAIL rr_hazard_grant c=%0d got %b exp %b", c, {req1_ready, req0_ready}, exp_r);
            end
            tick();
            if (c < 3) req1_instr = mk(0, 31 + c, 60 + c, 70 + c, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_tests++;
        if ({iss_valid, iss_rd, hazard_stall} !== {1'b1, RW'(30), 1'b0}) begin
            n_fail++; $display("FAIL rr_hazard_issue got v=%b rd=%0d s=%b exp 1/30/0", iss_valid, iss_rd, hazard_stall);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        req1_valid = 1'b1; req1_instr = mk(12, 7, 1, 2, 3);
        #1;
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_fail++; $display("FAIL illegal_ready got %b exp 10", {req1_ready, req0_ready});
        end
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_instr = mk(0, 8, 7, 7, 9);
        #1;
        n_tests++;
        if ({err, iss_valid, iss_rd} !== {1'b1, 1'b0, RW'(0)}) begin
            n_fail++; $display("FAIL illegal_flag got err=%b v=%b rd=%0d exp err=1 v=0 rd=0", err, iss_valid, iss_rd);
        end
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL illegal_no_hazard got %b exp 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        n_tests++;
        if ({err, iss_valid, iss_rs1, hazard_stall} !== {1'b0, 1'b1, RW'(7), 1'b0}) begin
            n_fail++; $display("FAIL illegal_follow_issue got err=%b v=%b rs1=%0d s=%b exp 0/1/7/0",
                               err, iss_valid, iss_rs1, hazard_stall);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        req0_valid = 1'b1; req0_instr = mk(0, 4, 1, 2, 0);
        tick();
        req0_instr = mk(0, 5, 4, 4, 0);
        tick();
        n_tests++;
        if ({hazard_stall, iss_rd} !== {1'b1, RW'(4)}) begin
            n_fail++; $display("FAIL midrst_pre got s=%b rd=%0d exp s=1 rd=4", hazard_stall, iss_rd);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req0_ready, iss_valid, hazard_stall, err, iss_rd, iss_rs1} !== '0) begin
            n_fail++; $display("FAIL midrst_clear got r=%b v=%b s=%b rd=%0d exp all 0",
                               req0_ready, iss_valid, hazard_stall, iss_rd);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_release_grant got %b exp 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        n_tests++;
        if ({iss_valid, iss_rd, iss_rs1} !== {1'b1, RW'(5), RW'(4)}) begin
            n_fail++; $display("FAIL midrst_issue got v=%b rd=%0d rs1=%0d exp 1/5/4", iss_valid, iss_rd, iss_rs1);
        end
    endtask

    // Reference model: a legal producer accepted at cycle t blocks readers of its rd
    // until cycle t+WB_LAT; priority goes to the requester not granted last.
    typedef struct { int rd; int cyc; } prod_t;
    prod_t prods[$];

    function automatic bit m_blocked(input logic [IW-1:0] ins, input int now);
        int f, r1, r2;
        bit u1, u2;
        f  = int'(ins[IW-1 -: FW]);
        r1 = int'(ins[AW+2*RW-1 -: RW]);
        r2 = int'(ins[AW+RW-1 -: RW]);
        if (f >= 12) return 1'b0;
        u1 = f inside {0, 1, 2, 3, 5, 6, 7, 8, 10, 11};
        u2 = f inside {0, 1, 2, 4, 5, 6, 7, 9};
        foreach (prods[i])
            if (now - prods[i].cyc < WB_LAT &&
                ((u1 && r1 == prods[i].rd) || (u2 && r2 == prods[i].rd)))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_random();
        bit            pv[2];
        logic [IW-1:0] pi[2];
        bit            e[2];
        int            g, last_g, cyc;
        bit            exp_v, exp_e, exp_s;
        logic [IW-1:0] exp_w;
        do_reset();
        prods.delete();
        pv[0] = 0; pv[1] = 0; pi[0] = '0; pi[1] = '0;
        last_g = 1; cyc = 0;
        exp_w = '0;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++)
                if (!pv[r] && $urandom_range(0, 3) != 0) begin
                    pv[r] = 1;
                    pi[r] = mk($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 7), $urandom_range(0, 1023));
                end
            req0_valid = pv[0]; req0_instr = pi[0];
            req1_valid = pv[1]; req1_instr = pi[1];
            #1;
            for (int r = 0; r < 2; r++) e[r] = pv[r] && !m_blocked(pi[r], cyc);
            if (e[0] && e[1]) g = (last_g == 0) ? 1 : 0;
            else if (e[0])    g = 0;
            else if (e[1])    g = 1;
            else              g = -1;
            n_tests++;
            if ({req1_ready, req0_ready} !== {g == 1, g == 0}) begin
                n_fail++; $display("FAIL rand_grant cyc=%0d got %b exp %b", cyc,
                                   {req1_ready, req0_ready}, {g == 1, g == 0});
            end
            exp_s = (pv[0] || pv[1]) && g < 0;
            exp_v = 0; exp_e = 0;
            if (g >= 0) begin
                if (int'(pi[g][IW-1 -: FW]) < 12) begin
                    exp_v = 1; exp_w = pi[g];
                    prods.push_back('{rd: int'(pi[g][AW+3*RW-1 -: RW]), cyc: cyc});
                end else begin
                    exp_e = 1;
                end
                last_g = g;
                pv[g] = 0;
            end
            while (prods.size() > 0 && cyc - prods[0].cyc >= WB_LAT) void'(prods.pop_front());
            tick();
            cyc++;
            n_tests++;
            if ({iss_valid, err, hazard_stall} !== {exp_v, exp_e, exp_s}) begin
                n_fail++; $display("FAIL rand_flags cyc=%0d got v/e/s=%b exp %b", cyc,
                                   {iss_valid, err, hazard_stall}, {exp_v, exp_e, exp_s});
            end
            n_tests++;
            if ({iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr} !== exp_w) begin
                n_fail++; $display("FAIL rand_fields cyc=%0d got %h exp %h", cyc,
                                   {iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr}, exp_w);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_instr = '0;   req1_instr = '0;
        test_reset();
        test_single_issue();
        test_raw_stall();
        test_round_robin();
        test_illegal();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
